// File: rtl/stoch_nn_pkg.sv
// Shared types for the stochastic activation window sequencer.
// State encoding and default widths.
package stoch_nn_pkg;

  localparam int DEF_WIN_W  = 10;
  localparam int DEF_WARM_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    WARM  = 3'd2,
    ACC   = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/stoch_ones_counter.sv
// Per-unit ones counter: sync clear (wins over enable), async reset.
// Ports: CLK, INIT_n, clr, en, count[W-1:0].
module stoch_ones_counter
  import stoch_nn_pkg::*;
#(
  parameter int W = DEF_WIN_W
) (
  input  logic         CLK,
  input  logic         INIT_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stoch_act_window_seq.sv
// Sequences one INIT/warm-up/accumulate window over a bank of
// stochastic activation units and hands counts out via valid/ready.
// Ports: CLK, INIT_n, start, abort, window_len, warmup_len, act_a,
//        act_init, stream_en, busy, count_out, out_valid, out_ready.
module stoch_act_window_seq
  import stoch_nn_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int WIN_W     = DEF_WIN_W,
  parameter int WARM_W    = DEF_WARM_W
) (
  input  logic                       CLK,
  input  logic                       INIT_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIN_W-1:0]           window_len,
  input  logic [WARM_W-1:0]          warmup_len,
  input  logic [NUM_UNITS-1:0]       act_a,
  output logic                       act_init,
  output logic                       stream_en,
  output logic                       busy,
  output logic [NUM_UNITS*WIN_W-1:0] count_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  state_t              state;
  logic [WIN_W-1:0]    win_q;
  logic [WARM_W-1:0]   warm_q;
  logic [WIN_W-1:0]    acc_cnt;
  logic [WARM_W-1:0]   warm_cnt;
  logic                take;
  logic                kill;

  // Abort beats a simultaneous start; start only counts in IDLE or
  // at the HOLD handshake.
  assign kill = abort & (state != IDLE);
  assign take = start & ~abort &
                ((state == IDLE) | ((state == HOLD) & out_ready));

  always_ff @(posedge CLK or negedge INIT_n) begin
    if (!INIT_n) begin
      state    <= IDLE;
      win_q    <= '0;
      warm_q   <= '0;
      acc_cnt  <= '0;
      warm_cnt <= '0;
    end else if (kill) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      warm_cnt <= '0;
    end else if (take) begin
      state    <= PULSE;
      win_q    <= window_len;
      warm_q   <= warmup_len;
      acc_cnt  <= '0;
      warm_cnt <= '0;
    end else begin
      unique case (state)
        PULSE: begin
          if (warm_q != '0)     state <= WARM;
          else if (win_q != '0) state <= ACC;
          else                  state <= HOLD;
        end
        WARM: begin
          if (warm_cnt == warm_q - WARM_W'(1))
            state <= (win_q != '0) ? ACC : HOLD;
          else
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
        ACC: begin
          if (acc_cnt == win_q - WIN_W'(1))
            state <= HOLD;
          else
            acc_cnt <= acc_cnt + WIN_W'(1);
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign act_init  = (state == PULSE);
  assign stream_en = (state == WARM) | (state == ACC);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_cnt
    stoch_ones_counter #(
      .W(WIN_W)
    ) u_cnt (
      .CLK   (CLK),
      .INIT_n(INIT_n),
      .clr   (take | kill),
      .en    ((state == ACC) & act_a[i]),
      .count (count_out[i*WIN_W +: WIN_W])
    );
  end

endmodule

// File: tb/tb_stoch_act_window_seq.sv
// Self-checking bench for stoch_act_window_seq.
// Cycle-indexed reference model of the window timeline.
module tb_stoch_act_window_seq;

  localparam int NU = 4;
  localparam int WW = 10;
  localparam int MW = 4;

  logic             CLK;
  logic             INIT_n;
  logic             start;
  logic             abort;
  logic [WW-1:0]    window_len;
  logic [MW-1:0]    warmup_len;
  logic [NU-1:0]    act_a;
  logic             act_init;
  logic             stream_en;
  logic             busy;
  logic [NU*WW-1:0] count_out;
  logic             out_valid;
  logic             out_ready;

  int n_chk;
  int n_pass;

  stoch_act_window_seq #(
    .NUM_UNITS(NU),
    .WIN_W    (WW),
    .WARM_W   (MW)
  ) dut (
    .CLK       (CLK),
    .INIT_n    (INIT_n),
    .start     (start),
    .abort     (abort),
    .window_len(window_len),
    .warmup_len(warmup_len),
    .act_a     (act_a),
    .act_init  (act_init),
    .stream_en (stream_en),
    .busy      (busy),
    .count_out (count_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // mode 0: random bits, 1: nominal pattern, 2: ones only before ACC
  function automatic logic [NU-1:0] gen(input int mode, input int k,
                                        input int w);
    logic [NU-1:0] v;
    v = '0;
    if (mode == 0) begin
      v = NU'($urandom);
    end else if (mode == 1) begin
      v[0] = 1'b1;
      if (k >= w + 2) v[1] = (((k - (w + 2)) % 2) == 0);
    end else begin
      if (k <= w + 1) v = '1;
    end
    return v;
  endfunction

  // Start accepted at edge 0; cycle k follows edge k-1.
  // PULSE=1, stream cycles 2..w+n+1, HOLD from w+n+2.
  task automatic run_window(input int w, input int n, input int mode,
                            output logic [NU*WW-1:0] expv,
                            output int se_n, output int vk);
    int            expc[NU];
    logic [NU-1:0] a;
    for (int i = 0; i < NU; i++) expc[i] = 0;
    se_n = 0;
    vk = 0;
    expv = '0;
    window_len = WW'(n);
    warmup_len = MW'(w);
    abort = 1'b0;
    start = 1'b1;
    out_ready = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    window_len = WW'($urandom);
    warmup_len = MW'($urandom);
    for (int k = 1; k <= w + n + 2; k++) begin
      n_chk++;
      if (act_init !== (k == 1))
        $display("FAIL act_init k=%0d got=%b exp=%b", k, act_init, k == 1);
      else n_pass++;
      n_chk++;
      if (stream_en !== (k >= 2 && k <= w + n + 1))
        $display("FAIL stream_en k=%0d got=%b", k, stream_en);
      else n_pass++;
      n_chk++;
      if (out_valid !== (k == w + n + 2))
        $display("FAIL out_valid k=%0d got=%b", k, out_valid);
      else n_pass++;
      n_chk++;
      if (busy !== 1'b1) $display("FAIL busy k=%0d got=%b exp=1", k, busy);
      else n_pass++;
      if (k == 1) begin
        n_chk++;
        if (count_out !== '0)
          $display("FAIL clear_on_start got=%h exp=0", count_out);
        else n_pass++;
      end
      if (stream_en === 1'b1) se_n++;
      if (out_valid === 1'b1 && vk == 0) vk = k;
      a = gen(mode, k, w);
      if (k >= w + 2 && k <= w + n + 1)
        for (int i = 0; i < NU; i++) expc[i] += int'(a[i]);
      act_a = a;
      if (k == w + n + 2) begin
        for (int i = 0; i < NU; i++) expv[i*WW +: WW] = WW'(expc[i]);
        n_chk++;
        if (count_out !== expv)
          $display("FAIL counts w=%0d n=%0d got=%h exp=%h",
                   w, n, count_out, expv);
        else n_pass++;
      end else begin
        step();
      end
    end
  endtask

  task automatic release_hold(input logic [NU*WW-1:0] expv);
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL release got busy=%b valid=%b exp=0/0", busy, out_valid);
    else n_pass++;
    n_chk++;
    if (count_out !== expv)
      $display("FAIL retain got=%h exp=%h", count_out, expv);
    else n_pass++;
  endtask

  task automatic test_reset();
    INIT_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    out_ready = 1'b0;
    window_len = WW'(5);
    warmup_len = MW'(1);
    act_a = '1;
    step();
    step();
    n_chk++;
    if ({busy, stream_en, act_init, out_valid} !== 4'b0 || count_out !== '0)
      $display("FAIL reset got busy=%b se=%b ai=%b ov=%b cnt=%h exp=0",
               busy, stream_en, act_init, out_valid, count_out);
    else n_pass++;
    start = 1'b0;
    INIT_n = 1'b1;
    step();
    step();
    n_chk++;
    if ({busy, stream_en, act_init, out_valid} !== 4'b0 || count_out !== '0)
      $display("FAIL idle got busy=%b se=%b ai=%b ov=%b cnt=%h exp=0",
               busy, stream_en, act_init, out_valid, count_out);
    else n_pass++;
  endtask

  task automatic test_nominal();
    logic [NU*WW-1:0] e;
    int se, vk;
    run_window(3, 16, 1, e, se, vk);
    n_chk++;
    if (se != 19) $display("FAIL nom_stream got=%0d exp=19", se);
    else n_pass++;
    n_chk++;
    if (vk != 21) $display("FAIL nom_valid_cycle got=%0d exp=21", vk);
    else n_pass++;
    n_chk++;
    if (count_out[0 +: WW] !== WW'(16) || count_out[WW +: WW] !== WW'(8))
      $display("FAIL nom_counts got u0=%0d u1=%0d exp=16/8",
               count_out[0 +: WW], count_out[WW +: WW]);
    else n_pass++;
    release_hold(e);
  endtask

  task automatic test_warmup_discard();
    logic [NU*WW-1:0] e;
    int se, vk;
    run_window(4, 8, 2, e, se, vk);
    n_chk++;
    if (count_out !== '0) $display("FAIL warm_discard got=%h exp=0", count_out);
    else n_pass++;
    release_hold(e);
  endtask

  task automatic test_zero_len();
    logic [NU*WW-1:0] e;
    int se, vk;
    run_window(0, 0, 0, e, se, vk);
    n_chk++;
    if (se != 0 || vk != 2)
      $display("FAIL zero_len got se=%0d vk=%0d exp=0/2", se, vk);
    else n_pass++;
    release_hold(e);
  endtask

  task automatic test_random();
    logic [NU*WW-1:0] e;
    int se, vk;
    for (int r = 0; r < 6; r++) begin
      run_window($urandom_range(0, 15), $urandom_range(0, 30), 0, e, se, vk);
      release_hold(e);
    end
    run_window(15, 1023, 0, e, se, vk);
    release_hold(e);
  endtask

  task automatic test_back_to_back();
    logic [NU*WW-1:0] e;
    int se, vk;
    run_window(2, 12, 0, e, se, vk);
    for (int c = 0; c < 5; c++) begin
      start = 1'(c % 2);
      out_ready = 1'b0;
      step();
      n_chk++;
      if (out_valid !== 1'b1 || act_init !== 1'b0 || count_out !== e)
        $display("FAIL backpressure c=%0d got ov=%b ai=%b cnt=%h exp=1/0/%h",
                 c, out_valid, act_init, count_out, e);
      else n_pass++;
    end
    run_window(1, 9, 0, e, se, vk);
    run_window(0, 5, 0, e, se, vk);
    release_hold(e);
  endtask

  task automatic test_abort();
    window_len = WW'(10);
    warmup_len = MW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    act_a = '1;
    for (int k = 1; k <= 8; k++) step();
    n_chk++;
    if (stream_en !== 1'b1 || count_out === '0)
      $display("FAIL abort_pre got se=%b cnt=%h exp=1/nonzero",
               stream_en, count_out);
    else n_pass++;
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || stream_en !== 1'b0 || count_out !== '0)
      $display("FAIL abort got busy=%b se=%b cnt=%h exp=0/0/0",
               busy, stream_en, count_out);
    else n_pass++;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_idle c=%0d got ov=%b busy=%b exp=0/0",
                 c, out_valid, busy);
      else n_pass++;
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL abort_vs_start got busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    window_len = WW'(4);
    warmup_len = MW'(6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_chk++;
    if (stream_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL async_pre got se=%b busy=%b exp=1/1", stream_en, busy);
    else n_pass++;
    #2;
    INIT_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, stream_en, act_init, out_valid} !== 4'b0 || count_out !== '0)
      $display("FAIL async_reset got busy=%b se=%b ai=%b ov=%b exp=0",
               busy, stream_en, act_init, out_valid);
    else n_pass++;
    INIT_n = 1'b1;
    step();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL async_after got busy=%b exp=0", busy);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_nominal();
    test_warmup_discard();
    test_zero_len();
    test_random();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stoch_act_window_seq.md
Name: stoch_act_window_seq

Overview:
- Sequences one evaluation window for a bank of NUM_UNITS stochastic softplus activation units.
- Pulses the units' INIT input so they restart from a known mode, then enables the stochastic number generators.
- Discards a programmable warm-up interval, then counts output '1's per unit over a programmable window.
- Presents the per-unit counts to the layer/readout logic with a valid/ready handshake.

Parameters:
- NUM_UNITS, 8: number of activation units served; must be >= 1.
- WIN_W, 10: width of window_len and of each per-unit count; maximum window is 2^WIN_W-1 cycles.
- WARM_W, 4: width of warmup_len.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- INIT_n  in  1  asynchronous active-low reset.
- start  in  1  request a new window; sampled only in IDLE or at a HOLD handshake.
- abort  in  1  synchronous cancel; highest priority after reset.
- window_len  in  WIN_W  accumulation length in cycles; latched at start acceptance.
- warmup_len  in  WARM_W  discard length in cycles; latched at start acceptance.
- act_a  in  NUM_UNITS  activation output bits, one per unit (the units' 'a').
- act_init  out  1  one-cycle pulse to the units' INIT inputs.
- stream_en  out  1  enables the upstream stochastic number generators.
- busy  out  1  high in any state other than IDLE.
- count_out  out  NUM_UNITS*WIN_W  per-unit ones count; unit i occupies bits [i*WIN_W +: WIN_W].
- out_valid  out  1  count_out is valid.
- out_ready  in  1  consumer accepts count_out.

Behaviour:
- Reset (INIT_n=0, async): state=IDLE; act_init=0; stream_en=0; busy=0; out_valid=0; all counts=0; latched lengths=0.
- States: IDLE, PULSE, WARM, ACC, HOLD. Outputs are Moore, decoded from registered state.
- IDLE: when start=1, latch window_len/warmup_len, clear all counts, go to PULSE.
- PULSE: act_init=1 for exactly one cycle. Next state is WARM if latched warmup>0, else ACC if latched window>0, else HOLD.
- WARM: stream_en=1. Warm-up counter runs from 0; counts are not updated. After exactly warmup_len cycles, go to ACC (or HOLD if window=0).
- ACC: stream_en=1. On every rising edge in ACC, count[i] += act_a[i]. After exactly window_len ACC cycles, go to HOLD.
- ACC overflow: a count never exceeds window_len <= 2^WIN_W-1, so no saturation logic is needed.
- HOLD: out_valid=1, stream_en=0; count_out is stable until handshake.
- HOLD, handshake (out_valid & out_ready) with start=0: go to IDLE. Counts are retained until the next start.
- HOLD, handshake with start=1: back-to-back window. Latch new lengths, clear counts, go to PULSE; no IDLE cycle in between.
- start outside IDLE, or in HOLD without out_ready: ignored (not queued).
- abort=1 in any non-IDLE state: next state IDLE; counts cleared; out_valid never asserts for the aborted window.
- abort and start both high in the same cycle: abort wins and start is ignored.
- window_len/warmup_len changes after start acceptance have no effect on the window in progress.
- Latency, start accepted at edge 0 (warmup W, window N > 0):
  - act_init high during cycle 1.
  - stream_en high for cycles 2 .. W+N+1.
  - out_valid first high in cycle W+N+2.
- INIT_n asserted mid-window: immediate reset to the values above. The units' own INIT is not driven by this block during INIT_n; the top level ORs the system reset into the unit INIT.

Decomposition:
- Shared package stoch_nn_pkg:
  - state encoding: 3-bit enum IDLE=0, PULSE=1, WARM=2, ACC=3, HOLD=4;
  - default widths WIN_W/WARM_W.
- One natural sub-module: stoch_ones_counter (WIN_W-bit counter with synchronous clear and enable), instantiated NUM_UNITS times via generate. The FSM and the length counters stay in the top module.

Test Plan:
- Reset/idle: INIT_n low then high, no start -> busy=0, stream_en=0, act_init=0, out_valid=0, count_out=0.
- Nominal: NUM_UNITS=2, warmup=3, window=16, act_a[0]=1 constantly, act_a[1] toggling 1,0,1,0 starting at first ACC cycle -> act_init single pulse; stream_en high exactly 19 cycles; counts {8,16}; out_valid 21 cycles after start edge.
- Warm-up discard: warmup=4, window=8, act_a=all-ones only during WARM, zero in ACC -> all counts 0.
- Zero lengths: warmup=0, window=0 -> PULSE then HOLD directly, counts 0, stream_en never high.
- Back-to-back and backpressure: hold out_ready=0 for 5 cycles in HOLD -> count_out stable, start ignored; then out_ready=1 with start=1 -> next cycle act_init=1, counts cleared.
- Abort and async reset: abort=1 in ACC after 5 cycles -> IDLE next cycle, counts 0, no out_valid. Separately, INIT_n low mid-WARM -> all outputs zero immediately, without waiting for a clock edge.
